// File: rtl/dumbrv_regs_pkg.sv
// Shared types, defaults and helpers for the dumbrv integer register file.
package dumbrv_regs_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 16;
    localparam int unsigned NWR_DEF   = 2;
    localparam int unsigned NRD_DEF   = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dumbrv_rr_arbiter.sv
// Round-robin arbiter: the granted requester drops to lowest priority on advance.
module dumbrv_rr_arbiter
    import dumbrv_regs_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_c_o,
    output logic [IW-1:0] grant_idx_c_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    // Scan ranks from the pointer upward; first requester at the lowest rank wins.
    always_comb begin
        grant_c_o     = '0;
        grant_idx_c_o = '0;
        found         = 1'b0;
        for (int rank = 0; rank < int'(N); rank++) begin
            for (int k = 0; k < int'(N); k++) begin
                int r;
                r = k - int'(ptr_q);
                if (r < 0) r = r + int'(N);
                if (!found && req_i[k] && (r == rank)) begin
                    found         = 1'b1;
                    grant_c_o[k]  = 1'b1;
                    grant_idx_c_o = IW'(k);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) ptr_d = IW'((32'(grant_idx_c_o) + 32'd1) % N);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dumbrv_regfile.sv
// Flop-based register file, x0 hard-wired to zero, serialised write ports.
// Define DUMBRV_REGFILE_BYPASS_EN to forward the in-flight write to reads during WRITE.
module dumbrv_regfile
    import dumbrv_regs_pkg::*;
#(
    parameter  int unsigned XLEN  = XLEN_DEF,
    parameter  int unsigned NREGS = NREGS_DEF,
    parameter  int unsigned NWR   = NWR_DEF,
    parameter  int unsigned NRD   = NRD_DEF,
    localparam int unsigned AW    = clog2(NREGS),
    localparam int unsigned GW    = (NWR > 1) ? clog2(NWR) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      wr_req,
    input  logic [NWR*AW-1:0]   wr_reg,
    input  logic [NWR*XLEN-1:0] wr_value,
    output logic [NWR-1:0]      wr_done,
    input  logic [NRD*AW-1:0]   rd_reg,
    output logic [NRD*XLEN-1:0] rd_value,
    output logic                busy
);

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_reg_q, wr_reg_d;
    logic [XLEN-1:0]   tmp_q, tmp_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [NWR-1:0]    wr_done_q, wr_done_d;
    logic              busy_q;
    logic              advance;
    logic              we;
    logic [NWR-1:0]    grant_oh;
    logic [GW-1:0]     grant_idx;
    logic [XLEN-1:0]   regs_q [NREGS];

    dumbrv_rr_arbiter #(.N(NWR)) u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (wr_req),
        .advance_i     (advance),
        .grant_c_o     (grant_oh),
        .grant_idx_c_o (grant_idx)
    );

    // Commit FSM: latch the granted request, write it, then pulse done.
    always_comb begin
        state_d   = state_q;
        wr_reg_d  = wr_reg_q;
        tmp_d     = tmp_q;
        grant_d   = grant_q;
        wr_done_d = '0;
        advance   = 1'b0;
        we        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|wr_req) begin
                    advance = 1'b1;
                    grant_d = grant_idx;
                    for (int p = 0; p < int'(NWR); p++) begin
                        if (grant_oh[p]) begin
                            wr_reg_d = wr_reg[p*AW +: AW];
                            tmp_d    = wr_value[p*XLEN +: XLEN];
                        end
                    end
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                we      = (wr_reg_q != '0);
                state_d = ST_DONE;
                for (int p = 0; p < int'(NWR); p++) begin
                    if (grant_q == GW'(p)) wr_done_d[p] = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_reg_q  <= '0;
            tmp_q     <= '0;
            grant_q   <= '0;
            wr_done_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_reg_q  <= wr_reg_d;
            tmp_q     <= tmp_d;
            grant_q   <= grant_d;
            wr_done_q <= wr_done_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // Entry 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else begin
            for (int i = 1; i < int'(NREGS); i++) begin
                if (we && (wr_reg_q == AW'(i))) regs_q[i] <= tmp_q;
            end
        end
    end

    always_comb begin
        rd_value = '0;
        for (int r = 0; r < int'(NRD); r++) begin
            logic [AW-1:0]   idx;
            logic [XLEN-1:0] val;
            idx = rd_reg[r*AW +: AW];
            val = regs_q[idx];
`ifdef DUMBRV_REGFILE_BYPASS_EN
            if ((state_q == ST_WRITE) && (idx == wr_reg_q)) val = tmp_q;
`endif
            if (idx == '0) val = '0;
            rd_value[r*XLEN +: XLEN] = val;
        end
    end

    assign wr_done = wr_done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_dumbrv_regfile.sv
// Directed bench for dumbrv_regfile: default build plus a 32x64, 3-write-port build.
module tb_dumbrv_regfile;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   wr_req;
    logic [7:0]   wr_reg;
    logic [63:0]  wr_value;
    logic [1:0]   wr_done;
    logic [7:0]   rd_reg;
    logic [63:0]  rd_value;
    logic         busy;

    logic [2:0]   wr_req1;
    logic [14:0]  wr_reg1;
    logic [191:0] wr_value1;
    logic [2:0]   wr_done1;
    logic [9:0]   rd_reg1;
    logic [127:0] rd_value1;
    logic         busy1;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_c1;
    logic [63:0] v0, v1, v2;
    logic [2:0]  exp_d1;

    dumbrv_regfile u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_req   (wr_req),
        .wr_reg   (wr_reg),
        .wr_value (wr_value),
        .wr_done  (wr_done),
        .rd_reg   (rd_reg),
        .rd_value (rd_value),
        .busy     (busy)
    );

    dumbrv_regfile #(.XLEN(64), .NREGS(32), .NWR(3), .NRD(2)) u_dut_wide (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_req   (wr_req1),
        .wr_reg   (wr_reg1),
        .wr_value (wr_value1),
        .wr_done  (wr_done1),
        .rd_reg   (rd_reg1),
        .rd_value (rd_value1),
        .busy     (busy1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef DUMBRV_REGFILE_BYPASS_EN
        exp_c1 = 32'hDEADBEEF;
`else
        exp_c1 = 32'h0;
`endif
        wr_req = '0; wr_reg = '0; wr_value = '0; rd_reg = '0;
        wr_req1 = '0; wr_reg1 = '0; wr_value1 = '0; rd_reg1 = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            rd_reg = {4'(15 - i), 4'(i)};
            #1;
            chk("rst_rd0", 64'(rd_value[31:0]), 64'h0);
            chk("rst_rd1", 64'(rd_value[63:32]), 64'h0);
        end
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(wr_done), 64'h0);

        // Simultaneous writes to reg 3: port 0 first after reset.
        wr_reg = {4'd3, 4'd3}; wr_value = {32'h22, 32'h11}; wr_req = 2'b11; rd_reg = {4'd3, 4'd3};
        #1;
        chk("pairA_c0_busy", 64'(busy), 64'h0);
        step(); chk("pairA_c1_done", 64'(wr_done), 64'h0); chk("pairA_c1_busy", 64'(busy), 64'h1);
        step(); chk("pairA_c2_done", 64'(wr_done), 64'h1); chk("pairA_c2_rd", 64'(rd_value[31:0]), 64'h11);
        wr_req[0] = 1'b0;
        step(); chk("pairA_c3_done", 64'(wr_done), 64'h0); chk("pairA_c3_busy", 64'(busy), 64'h0);
        step(); chk("pairA_c4_done", 64'(wr_done), 64'h0);
        step(); chk("pairA_c5_done", 64'(wr_done), 64'h2); chk("pairA_c5_rd", 64'(rd_value[63:32]), 64'h22);
        wr_req = 2'b00;
        step(); chk("pairA_c6_done", 64'(wr_done), 64'h0); chk("pairA_c6_busy", 64'(busy), 64'h0);

        // Single write port 0, reg 5.
        wr_reg[3:0] = 4'd5; wr_value[31:0] = 32'hDEADBEEF; wr_req = 2'b01; rd_reg = {4'd0, 4'd5};
        step(); chk("w5_c1_busy", 64'(busy), 64'h1); chk("w5_c1_done", 64'(wr_done), 64'h0);
        chk("w5_c1_rd", 64'(rd_value[31:0]), 64'(exp_c1));
        step(); chk("w5_c2_busy", 64'(busy), 64'h1); chk("w5_c2_done", 64'(wr_done), 64'h1);
        chk("w5_c2_rd", 64'(rd_value[31:0]), 64'hDEADBEEF);
        wr_req = 2'b00;
        step(); chk("w5_c3_busy", 64'(busy), 64'h0); chk("w5_c3_done", 64'(wr_done), 64'h0);

        // Pair again: port 0 was granted last, so port 1 now wins.
        wr_reg = {4'd3, 4'd3}; wr_value = {32'h44, 32'h33}; wr_req = 2'b11; rd_reg = {4'd3, 4'd3};
        step(); chk("pairB_c1_done", 64'(wr_done), 64'h0);
        step(); chk("pairB_c2_done", 64'(wr_done), 64'h2); chk("pairB_c2_rd", 64'(rd_value[31:0]), 64'h44);
        wr_req[1] = 1'b0;
        step(); chk("pairB_c3_done", 64'(wr_done), 64'h0);
        step(); chk("pairB_c4_done", 64'(wr_done), 64'h0);
        step(); chk("pairB_c5_done", 64'(wr_done), 64'h1); chk("pairB_c5_rd", 64'(rd_value[63:32]), 64'h33);
        wr_req = 2'b00;
        step(); chk("pairB_c6_busy", 64'(busy), 64'h0);

        // Write to reg 0 completes but is discarded.
        wr_reg = {4'd0, 4'd0}; wr_value = {32'hFFFFFFFF, 32'h0}; wr_req = 2'b10; rd_reg = {4'd0, 4'd0};
        step(); chk("x0_c1_rd", 64'(rd_value[31:0]), 64'h0);
        step(); chk("x0_c2_done", 64'(wr_done), 64'h2); chk("x0_c2_rd", 64'(rd_value[63:32]), 64'h0);
        wr_req = 2'b00;
        step(); chk("x0_c3_done", 64'(wr_done), 64'h0); chk("x0_c3_rd", 64'(rd_value[31:0]), 64'h0);

        // Reset during WRITE of reg 7.
        wr_reg = {4'd0, 4'd7}; wr_value = {32'h0, 32'h55}; wr_req = 2'b01; rd_reg = {4'd5, 4'd7};
        step(); chk("rstw_c1_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("rstw_busy", 64'(busy), 64'h0); chk("rstw_done", 64'(wr_done), 64'h0);
        wr_req = 2'b00;
        step(); step();
        chk("rstw_hold_done", 64'(wr_done), 64'h0);
        rst_n = 1'b1;
        step();
        chk("rstw_rd7", 64'(rd_value[31:0]), 64'h0);
        chk("rstw_rd5", 64'(rd_value[63:32]), 64'h0);
        chk("rstw_busy_after", 64'(busy), 64'h0);
        chk("rstw_done_after", 64'(wr_done), 64'h0);

        // Wide build: three simultaneous writes, granted 0/1/2 three cycles apart.
        v0 = 64'h0123456789ABCDEF; v1 = 64'hFEDCBA9876543210; v2 = 64'h8000000000000001;
        wr_reg1 = {5'd29, 5'd30, 5'd31}; wr_value1 = {v2, v1, v0}; wr_req1 = 3'b111;
        for (int c = 1; c <= 9; c++) begin
            step();
            exp_d1 = (c == 2) ? 3'b001 : (c == 5) ? 3'b010 : (c == 8) ? 3'b100 : 3'b000;
            chk($sformatf("wide_c%0d_done", c), 64'(wr_done1), 64'(exp_d1));
            if (c == 2) wr_req1[0] = 1'b0;
            if (c == 5) wr_req1[1] = 1'b0;
            if (c == 8) wr_req1[2] = 1'b0;
        end
        rd_reg1 = {5'd30, 5'd31};
        #1;
        chk("wide_rd31", rd_value1[63:0], v0);
        chk("wide_rd30", rd_value1[127:64], v1);
        rd_reg1 = {5'd0, 5'd29};
        #1;
        chk("wide_rd29", rd_value1[63:0], v2);
        chk("wide_rd0", rd_value1[127:64], 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dumbrv_regfile.md
# dumbrv_regfile

Parametrised, flop-based integer register file for the dumbrv core, replacing the fixed 16x32 two-write-port latch file. It holds NREGS registers of XLEN bits with register 0 hard-wired to zero. NWR write ports are serialised through a round-robin arbiter and a three-state commit FSM, each with a request/done handshake. NRD read ports are combinational. It sits between decode (read operands) and the execute/load-store writeback paths (write ports).

## Interface
- XLEN, 32: register width in bits.
- NREGS, 16: number of registers, power of two, 2..32; AW = clog2(NREGS).
- NWR, 2: number of write ports, 1..4.
- NRD, 2: number of read ports, 1..4.

- clk  in  1: clock, all state on posedge.
- rst_n  in  1: asynchronous active-low reset.
- wr_req  in  NWR: per-port write request, held high until that port's wr_done.
- wr_reg  in  NWR*AW: per-port destination index (port p at [p*AW +: AW]), stable while wr_req is high.
- wr_value  in  NWR*XLEN: per-port write data, stable while wr_req is high.
- wr_done  out  NWR: one-cycle completion pulse for the granted port.
- rd_reg  in  NRD*AW: per-port read index.
- rd_value  out  NRD*XLEN: per-port read data, combinational.
- busy  out  1: high whenever the FSM is not IDLE.

## Operation
- FSM states:
  - IDLE: if any wr_req bit is set, grant one port, latch its wr_reg into wr_reg_q and its wr_value into tmp_q, record grant_q, then go to WRITE. Otherwise stay in IDLE.
  - WRITE: at the closing edge, regs[wr_reg_q] <= tmp_q unless wr_reg_q == 0. Then go to DONE.
  - DONE: wr_done[grant_q] = 1 for this cycle only. No grant is made. Then go to IDLE.
- Arbitration is round-robin. The granted port becomes lowest priority. The priority pointer resets so that port 0 wins first.
- A write to register 0 is accepted and completes with a normal wr_done, but it is discarded. rd_value for index 0 is always 0.
- Requester rule: drop wr_req (or present a new write) at the edge that ends its wr_done cycle. A request still high in IDLE is treated as a new write.
- Read ports are independent. Any number may address the same register, including the one being written.
- State encodings and unused FSM codes: any unused code returns to IDLE on the next edge. No wr_done is issued from an unused code.

## Timing
- Reset values: state IDLE, wr_done 0, busy 0, all registers 0, tmp_q/wr_reg_q/grant_q 0, RR pointer set so port 0 has highest priority.
- Write latency, with wr_req high in cycle 0 and the FSM in IDLE:
  - cycle 1: WRITE.
  - cycle 2: DONE, wr_done high, new value visible on rd_value.
  - cycle 3: IDLE, earliest next grant.
- Throughput: one write per 3 cycles.
- Simultaneous requests are granted in RR order, 3 cycles apart. A port that is still waiting keeps wr_req high and is not lost.
- Reset mid-operation (WRITE or DONE): the pending write is dropped, no wr_done is issued, and all registers are cleared.
- Inputs sampled in IDLE only. wr_reg/wr_value changes in WRITE or DONE have no effect.

## Configuration
- DUMBRV_REGFILE_BYPASS_EN defined:
  - During WRITE, any read port with rd_reg == wr_reg_q (and != 0) returns tmp_q. The new value is visible from cycle 1.
  - The array commit and wr_done timing are unchanged.
- Not defined: reads return array contents only, and the new value is visible from cycle 2.

## Structure
- Package dumbrv_regs_pkg holds:
  - the FSM state typedef (IDLE, WRITE, DONE);
  - localparam defaults for XLEN, NREGS, NWR, NRD;
  - a clog2 helper function.
- Sub-module dumbrv_rr_arbiter (parameter N): inputs req[N] and an advance strobe; outputs a one-hot grant and the grant index. It owns the priority pointer and updates it only on advance, which the FSM pulses when leaving IDLE with a grant.
- The register array, bypass mux and FSM live in dumbrv_regfile.

## Test plan
- Reset, then read all indices on both read ports -> all 0, busy 0, wr_done 0.
- Port 0 writes reg 5 = 0xDEADBEEF -> busy in cycles 1-2, wr_done[0] in cycle 2 only, rd_value(5) = 0xDEADBEEF from cycle 2, or from cycle 1 with BYPASS_EN.
- Port 0 and port 1 request reg 3 = 0x11 and reg 3 = 0x22 in the same cycle -> port 0 done in cycle 2, port 1 done in cycle 5, final reg 3 = 0x22. Repeating the pair gives port 1 first.
- Write reg 0 = 0xFFFFFFFF -> wr_done pulses in cycle 2, rd_value(0) stays 0.
- Assert rst_n low during WRITE of reg 7 = 0x55 -> no wr_done, reg 7 = 0, state IDLE after release.
- NREGS=32, XLEN=64, NWR=3 build: three simultaneous writes to regs 31/30/29 -> dones in cycles 2/5/8 in port order 0/1/2, all values read back intact.
